// File: rtl/ep_bin_encoder.sv
// ep_bin_encoder: CABAC bypass bin encoder with 0xFF-run carry resolution and byte stream output.
// Optional EP_ENC_STATS_EN adds stat_bins/stat_bytes counters.
module ep_bin_encoder #(
  parameter int RANGE_W = 9,
  parameter int RUN_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bin_valid,
  input  logic               bin,
  input  logic [RANGE_W-1:0] range_in,
  output logic               bin_ready,
  input  logic               flush_req,
  output logic [7:0]         byte_data,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               byte_last,
  output logic               busy
`ifdef EP_ENC_STATS_EN
  ,
  output logic [31:0]        stat_bins,
  output logic [31:0]        stat_bytes
`endif
);
  typedef enum logic [1:0] {IDLE, WRITE, EMIT, FLUSH} state_t;
  state_t state, state_nx;
  logic [31:0] low, low_s;
  logic [5:0] bits_left, sh, n;
  logic [7:0] buf_byte, rep_byte;
  logic [RUN_W-1:0] num_buf, rep_cnt;
  logic [15:0] tail_word, tail_al;
  logic [1:0] tail_n;
  logic [8:0] lead;
  logic last, c, take_bin, take_flush, hs, done;
  always_comb begin
    bin_ready = state == IDLE;
    busy = state != IDLE;
    byte_valid = state == EMIT || state == FLUSH;
    byte_last = byte_valid && last;
    take_flush = bin_ready && flush_req;
    take_bin = bin_ready && bin_valid && !flush_req;
    hs = byte_valid && byte_ready;
    done = hs && rep_cnt == '0 && tail_n == 2'd0;
    lead = 9'(low >> (6'd24 - bits_left));
    sh = 6'd32 - bits_left;
    c = (low >> sh) != 32'd0;
    low_s = low - (c ? 32'd1 << sh : 32'd0);
    n = 6'd24 - bits_left;
    tail_al = {4'b0, low_s[19:8]} << (6'd16 - n);
    state_nx = state;
    case (state)
      IDLE:    state_nx = take_flush ? FLUSH : (take_bin && bits_left == 6'd12) ? WRITE : IDLE;
      WRITE:   state_nx = (lead == 9'h0FF || num_buf == '0) ? IDLE : EMIT;
      EMIT:    state_nx = done ? IDLE : EMIT;
      default: state_nx = done ? IDLE : FLUSH;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low <= '0;
      bits_left <= 6'd23;
      buf_byte <= 8'hFF;
      num_buf <= '0;
      byte_data <= '0;
      rep_byte <= '0;
      rep_cnt <= '0;
      tail_word <= '0;
      tail_n <= '0;
      last <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (take_flush) begin
            // A pending carry or buffered run goes out ahead of the tail bits
            if (c || num_buf != '0) begin
              byte_data <= buf_byte + {7'b0, c};
              rep_byte <= c ? 8'h00 : 8'hFF;
              rep_cnt <= num_buf == '0 ? '0 : num_buf - RUN_W'(1);
              tail_word <= tail_al;
              tail_n <= n > 6'd8 ? 2'd2 : 2'd1;
              last <= 1'b0;
            end else begin
              byte_data <= tail_al[15:8];
              tail_word <= tail_al << 8;
              tail_n <= n > 6'd8 ? 2'd1 : 2'd0;
              rep_cnt <= '0;
              last <= n <= 6'd8;
            end
          end else if (take_bin) begin
            low <= (low << 1) + (bin ? 32'(range_in) : 32'd0);
            bits_left <= bits_left - 6'd1;
          end
        WRITE: begin
          bits_left <= bits_left + 6'd8;
          low <= low & (32'hFFFF_FFFF >> (bits_left + 6'd8));
          if (lead == 9'h0FF) begin
            if (num_buf != '1) num_buf <= num_buf + RUN_W'(1);
          end else begin
            if (num_buf != '0) begin
              byte_data <= buf_byte + {7'b0, lead[8]};
              rep_byte <= 8'hFF + {7'b0, lead[8]};
              rep_cnt <= num_buf - RUN_W'(1);
              tail_n <= 2'd0;
              last <= 1'b0;
            end
            buf_byte <= lead[7:0];
            num_buf <= RUN_W'(1);
          end
        end
        default:
          if (hs) begin
            if (rep_cnt != '0) begin
              byte_data <= rep_byte;
              rep_cnt <= rep_cnt - RUN_W'(1);
            end else if (tail_n != 2'd0) begin
              byte_data <= tail_word[15:8];
              tail_word <= tail_word << 8;
              tail_n <= tail_n - 2'd1;
              last <= tail_n == 2'd1;
            end else if (state == FLUSH) begin
              low <= '0;
              bits_left <= 6'd23;
              buf_byte <= 8'hFF;
              num_buf <= '0;
              byte_data <= '0;
              last <= 1'b0;
            end
          end
      endcase
    end
  end
`ifdef EP_ENC_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_bins <= '0;
      stat_bytes <= '0;
    end else begin
      stat_bins <= stat_bins + {31'b0, take_bin};
      stat_bytes <= stat_bytes + {31'b0, hs};
    end
`endif
endmodule
